// File: rtl/wavelet_threshold_mc.sv
// wavelet_threshold_mc: multi-level wavelet detail denoiser. Each level keeps a
// windowed mean-|d| noise estimate that scales into a universal threshold, then
// applies hard/soft shrinkage over a fixed 2-cycle pipeline. A global FSM
// tracks threshold validity and the one-time lock/release.

module wavelet_threshold_lane #(
  parameter int DW  = 14,
  parameter int KW  = 6,
  parameter int KF  = 4,
  parameter int WLM = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          s1_vld,
  input  logic          clr,
  input  logic          win_end,
  input  logic          load,
  input  logic          idle,
  input  logic [4:0]    wl,
  input  logic [1:0]    mode,
  input  logic          en,
  input  logic [DW-1:0] d,
  input  logic [KW-1:0] k,
  output logic [DW-1:0] out,
  output logic [DW-1:0] thr
);
  localparam int AW = DW - 1 + WLM;
  localparam int MW = AW + KW;
  localparam logic [DW-1:0] TMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DW-2:0] a;
    logic [DW-2:0] t;
    logic [1:0]    mode;
    logic          en;
  } s1_t;

  logic [DW-2:0] a;
  logic [AW-1:0] acc, acc_nxt;
  logic [MW-1:0] prod;
  logic [DW-1:0] cand, cand_q;
  logic [DW-2:0] diff;
  s1_t           s1;

  // magnitude; the most negative code saturates instead of wrapping
  always_comb begin
    if (d == DMIN) a = TMAX[DW-2:0];
    else           a = (DW-1)'(d[DW-1] ? -d : d);
  end

  // window sum including this sample, and the threshold it would produce
  always_comb begin
    acc_nxt = acc + AW'(a);
    prod    = (MW'(acc_nxt >> wl) * MW'(k)) >> KF;
    cand    = (prod > MW'(TMAX)) ? TMAX : prod[DW-1:0];
  end

  // accumulator, candidate captured at window end, threshold loaded a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cand_q <= '0;
      thr    <= '0;
    end else begin
      if (clr || win_end) acc <= '0;
      else if (in_valid)  acc <= acc_nxt;
      if (win_end) cand_q <= cand;
      if (load)    thr    <= cand_q;
    end
  end

  // stage 1: sample, magnitude and the threshold in effect on the input cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1 <= '0;
    else if (in_valid) begin
      s1.d    <= d;
      s1.a    <= a;
      s1.t    <= idle ? '0 : thr[DW-2:0];
      s1.mode <= mode;
      s1.en   <= en;
    end
  end

  assign diff = s1.a - s1.t;

  // stage 2: shrinkage rule; output holds between valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else if (s1_vld) begin
      if (!s1.en || s1.mode == 2'b00 || s1.mode == 2'b11) out <= s1.d;
      else if (s1.a <= s1.t)                             out <= '0;
      else if (s1.mode == 2'b01)                         out <= s1.d;
      else out <= s1.d[DW-1] ? -{1'b0, diff} : {1'b0, diff};
    end
  end
endmodule

module wavelet_threshold_mc #(
  parameter int DATA_WIDTH  = 14,
  parameter int NUM_LEVELS  = 2,
  parameter int K_WIDTH     = 6,
  parameter int K_FRAC      = 4,
  parameter int WIN_LOG_MAX = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [NUM_LEVELS*DATA_WIDTH-1:0] detail_in,
  input  logic [1:0]                       cfg_mode,
  input  logic [NUM_LEVELS*K_WIDTH-1:0]    cfg_k,
  input  logic [4:0]                       cfg_win_log,
  input  logic [NUM_LEVELS-1:0]            cfg_denoise_en,
  input  logic                             cfg_one_time_lock,
  input  logic                             cfg_release,
  output logic                             out_valid,
  output logic [NUM_LEVELS*DATA_WIDTH-1:0] detail_out,
  output logic [NUM_LEVELS*DATA_WIDTH-1:0] thr_out,
  output logic                             thr_valid,
  output logic                             thr_locked
);
  localparam int STAGES = 2;
  localparam int WLM    = WIN_LOG_MAX;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, RESTART} state_t;

  state_t                                   state;
  logic [WLM-1:0]                           cnt, mask;
  logic [4:0]                               wl, wl_raw_q, shamt;
  logic                                     win_chg, clr, win_end, pend;
  logic [STAGES:1]                          vld_pipe;
  logic [NUM_LEVELS-1:0][DATA_WIDTH-1:0]    d_lv, out_lv, thr_lv;

  assign d_lv       = detail_in;
  assign detail_out = out_lv;
  assign thr_out    = thr_lv;

  // clamp window length and build the last-sample count for it
  always_comb begin
    wl = cfg_win_log;
    if (cfg_win_log == 5'd0)            wl = 5'd1;
    else if (cfg_win_log > 5'(WLM))     wl = 5'(WLM);
    shamt = 5'(WLM) - wl;
    mask  = {WLM{1'b1}} >> shamt;
  end

  // release and window-length changes both restart the window; release beats window end
  assign win_chg = (cfg_win_log != wl_raw_q);
  assign clr     = cfg_release | win_chg;
  assign win_end = in_valid & ~clr & (cnt == mask);

  // shared sample counter, config shadow, pending threshold load, valid pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wl_raw_q <= '0;
      pend     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (clr || win_end) cnt <= '0;
      else if (in_valid)  cnt <= cnt + WLM'(1);
      wl_raw_q <= cfg_win_log;
      pend     <= win_end && (state != LOCKED);
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end
  end

  // threshold lifecycle: first window, tracking, frozen, restart after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (win_end) state <= TRACK;
        TRACK:   if (cfg_release) state <= RESTART;
                 else if (win_end && cfg_one_time_lock) state <= LOCKED;
        LOCKED:  if (cfg_release) state <= RESTART;
        RESTART: if (!cfg_release) state <= TRACK;
        default: state <= IDLE;
      endcase
    end
  end

  assign thr_valid  = (state != IDLE);
  assign thr_locked = (state == LOCKED);
  assign out_valid  = vld_pipe[STAGES];

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lane
    wavelet_threshold_lane #(
      .DW(DATA_WIDTH), .KW(K_WIDTH), .KF(K_FRAC), .WLM(WLM)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_valid(in_valid),
      .s1_vld  (vld_pipe[1]),
      .clr     (clr),
      .win_end (win_end),
      .load    (pend),
      .idle    (state == IDLE),
      .wl      (wl),
      .mode    (cfg_mode),
      .en      (cfg_denoise_en[l]),
      .d       (d_lv[l]),
      .k       (cfg_k[l*K_WIDTH +: K_WIDTH]),
      .out     (out_lv[l]),
      .thr     (thr_lv[l])
    );
  end
endmodule

// File: tb/tb_wavelet_threshold_mc.sv
// Scoreboard bench for wavelet_threshold_mc: directed threshold scenarios plus a
// randomized stream, checked against a window-level reference model.
module tb_wavelet_threshold_mc;
  localparam int DW = 14, NL = 2, KW = 6, KF = 4, WLM = 16;
  localparam int TMAX = (1 << (DW-1)) - 1;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [NL*DW-1:0] detail_in = '0;
  logic [1:0]       cfg_mode = '0;
  logic [NL*KW-1:0] cfg_k = '0;
  logic [4:0]       cfg_win_log = 5'd2;
  logic [NL-1:0]    cfg_denoise_en = '1;
  logic             cfg_one_time_lock = 1'b0, cfg_release = 1'b0;
  logic             out_valid, thr_valid, thr_locked;
  logic [NL*DW-1:0] detail_out, thr_out;

  wavelet_threshold_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .detail_in(detail_in),
    .cfg_mode(cfg_mode), .cfg_k(cfg_k), .cfg_win_log(cfg_win_log),
    .cfg_denoise_en(cfg_denoise_en), .cfg_one_time_lock(cfg_one_time_lock),
    .cfg_release(cfg_release), .out_valid(out_valid), .detail_out(detail_out),
    .thr_out(thr_out), .thr_valid(thr_valid), .thr_locked(thr_locked)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0, checks = 0;

  typedef struct { int due; logic [NL*DW-1:0] data; } exp_t;
  exp_t sb[$];
  logic [NL*DW-1:0] last_out = '0;

  // next-cycle config, applied together with the sample
  logic [1:0] n_mode = 2'b01; logic [NL*KW-1:0] n_k = {6'd20, 6'd16};
  logic [4:0] n_wl = 5'd2; logic [NL-1:0] n_en = '1; logic n_lock = 0, n_rel = 0;

  // reference model: window sums per level, validity / lock flags
  int thr_m[NL], cand_m[NL], sum_m[NL];
  int cnt_m, wlq_m;
  bit tv, locked, pend_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int absd(input int x);
    if (x == -(1 << (DW-1))) return TMAX;
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [NL*DW-1:0] pk(input int a0, input int a1);
    logic [NL*DW-1:0] r;
    r[0 +: DW] = DW'(a0);
    r[DW +: DW] = DW'(a1);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    int v;
    case ($urandom_range(0, 15))
      0:       return {1'b1, {(DW-1){1'b0}}};
      1, 2, 3, 4, 5, 6, 7, 8: begin v = int'($urandom_range(0, 80)) - 40; return DW'(v); end
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin thr_m[l] = 0; cand_m[l] = 0; sum_m[l] = 0; end
    cnt_m = 0; wlq_m = 0; tv = 0; locked = 0; pend_m = 0;
  endtask

  // apply inputs for this cycle and advance the model across the next edge
  task automatic drive_and_model(input bit v, input logic [NL*DW-1:0] d);
    exp_t e; int wl, a, t, dd, o; bit chg, pend_n;
    in_valid = v; detail_in = d; cfg_mode = n_mode; cfg_k = n_k; cfg_win_log = n_wl;
    cfg_denoise_en = n_en; cfg_one_time_lock = n_lock; cfg_release = n_rel;
    if (v) begin
      e.data = '0;
      for (int l = 0; l < NL; l++) begin
        dd = $signed(d[l*DW +: DW]);
        a = absd(dd);
        t = tv ? thr_m[l] : 0;
        if (!cfg_denoise_en[l] || cfg_mode == 2'b00 || cfg_mode == 2'b11) o = dd;
        else if (a <= t) o = 0;
        else if (cfg_mode == 2'b01) o = dd;
        else o = (dd < 0) ? -(a - t) : (a - t);
        e.data[l*DW +: DW] = DW'(o);
      end
      e.due = cyc + 2;
      sb.push_back(e);
    end
    if (pend_m) for (int l = 0; l < NL; l++) thr_m[l] = cand_m[l];
    pend_n = 0;
    chg = (int'(cfg_win_log) != wlq_m);
    wlq_m = int'(cfg_win_log);
    wl = (cfg_win_log == 0) ? 1 : ((cfg_win_log > WLM) ? WLM : int'(cfg_win_log));
    if (cfg_release || chg) begin
      cnt_m = 0;
      for (int l = 0; l < NL; l++) sum_m[l] = 0;
      if (cfg_release && tv) locked = 0;
    end else if (v) begin
      for (int l = 0; l < NL; l++) sum_m[l] += absd($signed(d[l*DW +: DW]));
      if (cnt_m == (1 << wl) - 1) begin
        for (int l = 0; l < NL; l++) begin
          longint c;
          c = ((longint'(sum_m[l]) / (longint'(1) << wl)) * longint'(cfg_k[l*KW +: KW])) / (1 << KF);
          cand_m[l] = (c > TMAX) ? TMAX : int'(c);
          sum_m[l] = 0;
        end
        cnt_m = 0;
        if (!locked) pend_n = 1;
        if (!tv) tv = 1;
        else if (cfg_one_time_lock && !locked) locked = 1;
      end else cnt_m++;
    end
    pend_m = pend_n;
  endtask

  task automatic step(input bit v, input logic [NL*DW-1:0] d);
    @(negedge clk);
    for (int l = 0; l < NL; l++)
      chk($sformatf("thr_out_l%0d", l), 64'(thr_out[l*DW +: DW]), 64'(thr_m[l]));
    chk("thr_valid", thr_valid, tv);
    chk("thr_locked", thr_locked, locked);
    drive_and_model(v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_detail_out"}, detail_out, 0);
    chk({tag, "_thr_out"}, thr_out, 0);
    chk({tag, "_thr_valid"}, thr_valid, 0);
    chk({tag, "_thr_locked"}, thr_locked, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    drive_and_model(0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midrst");
    @(negedge clk);
    release_reset();
  endtask

  task automatic window4(input int a0, input int a1, input int a2, input int a3);
    step(1, pk(a0, $urandom_range(0, 30)));
    step(1, pk(a1, $urandom_range(0, 30)));
    step(1, pk(a2, $urandom_range(0, 30)));
    step(1, pk(a3, $urandom_range(0, 30)));
  endtask

  // output monitor: pop on every valid output, check data, latency and hold
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      last_out = '0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("detail_out", detail_out, e.data);
        chk("latency_cycle", cyc, e.due);
        last_out = e.data;
      end
    end else begin
      chk("detail_out_held", detail_out, last_out);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_out_valid: got out_valid=0 expected 1 (due cycle %0d) at cycle %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12 check_zero_outputs("reset");
    release_reset();
    idle(2);

    // first window: L0 mean 6, k=1.0
    window4(4, -4, 8, -8);
    idle(2);
    chk("t1_thr_l0", thr_out[0 +: DW], 6);
    chk("t1_thr_valid", thr_valid, 1);

    // hard threshold at 6
    window4(5, -7, 6, -32);
    idle(2);
    // restore threshold 6, then soft
    n_mode = 2'b00;
    window4(6, -6, 6, -6);
    idle(2);
    chk("t3_thr_l0", thr_out[0 +: DW], 6);
    n_mode = 2'b10;
    window4(5, -7, 20, -8192);
    idle(2);

    // lock at window end, then a window of 100s must not move the threshold
    n_mode = 2'b01;
    n_lock = 1;
    window4(2, 2, 2, 2);
    n_lock = 0;
    idle(2);
    window4(100, -100, 100, -100);
    idle(2);
    chk("t4_thr_frozen", thr_out[0 +: DW], 2);
    chk("t4_locked", thr_locked, 1);
    n_rel = 1; step(0, '0); n_rel = 0;
    window4(10, 10, -10, 10);
    idle(2);
    chk("t4_thr_after_release", thr_out[0 +: DW], 10);

    // release coincident with window end discards that window
    step(1, pk(50, 1)); step(1, pk(50, 1)); step(1, pk(50, 1));
    n_rel = 1; step(1, pk(50, 1)); n_rel = 0;
    idle(2);
    chk("t5_thr_kept", thr_out[0 +: DW], 10);
    window4(30, -30, 30, 30);
    idle(2);
    chk("t5_full_window", thr_out[0 +: DW], 30);

    // randomized stream with config churn
    for (int i = 0; i < 700; i++) begin
      if (i % 25 == 0) begin n_mode = 2'($urandom); n_en = NL'($urandom); n_k = (NL*KW)'($urandom); end
      if (i % 40 == 0) n_wl = 5'($urandom_range(0, 4));
      n_lock = ($urandom_range(0, 29) == 0);
      n_rel  = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, {rnd_d(), rnd_d()});
    end
    n_lock = 0; n_rel = 0; n_wl = 5'd3;

    // reset mid-window with gaps in the stream
    for (int i = 0; i < 13; i++) step($urandom_range(0, 1), {rnd_d(), rnd_d()});
    do_reset();
    for (int i = 0; i < 60; i++) step($urandom_range(0, 2) != 0, {rnd_d(), rnd_d()});
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
